// File: rtl/srff_pkg.sv
`default_nettype none
// ============================================================================
// srff_pkg: state encoding and counter-width helper shared by srff_cmd_driver
// Rev 1.0
// ============================================================================
package srff_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    GAP  = ST_GAP
  } state_e;

  // Bits needed to hold max_val (never less than 1); equals $clog2(max_val+1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= max_val) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/srff_debounce.sv
`default_nettype none
// ============================================================================
// srff_debounce: 2-flop synchroniser, counting debouncer and rising-edge pulse
// Rev 1.0
// ============================================================================
module srff_debounce
  import srff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic cl,
  input  logic raw,
  output logic rise
);

  localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/srff_cmd_driver.sv
`default_nettype none
// ============================================================================
// srff_cmd_driver: turns bouncy set/reset requests into spaced, exclusive s/r pulses
// Rev 1.0
// ============================================================================
module srff_cmd_driver
  import srff_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 1,
  parameter int PRIORITY_SET    = 1
) (
  input  logic clk,
  input  logic cl,
  input  logic set_in,
  input  logic rst_in,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic drop
);

  localparam int            PULSE_LAST = PULSE_CYCLES - 1;
  localparam int            GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int            CW         = cnt_width((PULSE_LAST > GAP_LAST) ? PULSE_LAST : GAP_LAST);
  localparam logic [CW-1:0] C_PULSE    = CW'(PULSE_LAST);
  localparam logic [CW-1:0] C_GAP      = CW'(GAP_LAST);
  localparam bit            HAS_GAP    = (GAP_CYCLES > 0);
  localparam bit            SET_FIRST  = (PRIORITY_SET != 0);

  logic          rise_s, rise_r;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d, r_q, r_d;
  logic          pend_s_q, pend_s_d, pend_r_q, pend_r_d;
  logic          busy_q, conflict_q, conflict_d, drop_q, drop_d;
  logic          req_s, req_r, pick_s, launch, issue_s, issue_r;

  srff_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk  (clk),
    .cl   (cl),
    .raw  (set_in),
    .rise (rise_s)
  );

  srff_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
    .clk  (clk),
    .cl   (cl),
    .raw  (rst_in),
    .rise (rise_r)
  );

  always_comb begin
    req_s   = pend_s_q | rise_s;
    req_r   = pend_r_q | rise_r;
    pick_s  = SET_FIRST ? req_s : (req_s & ~req_r);
    launch  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = 1'b0;
    r_d     = 1'b0;

    // A finishing gap (or a finishing pulse with no gap) arbitrates directly,
    // so consecutive pulses are separated by exactly GAP_CYCLES idle cycles.
    case (state_q)
      IDLE: launch = 1'b1;
      HOLD: begin
        if (cnt_q == '0) begin
          if (HAS_GAP) begin
            state_d = GAP;
            cnt_d   = C_GAP;
          end else begin
            launch = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          s_d   = s_q;
          r_d   = r_q;
        end
      end
      GAP: begin
        if (cnt_q == '0) launch = 1'b1;
        else             cnt_d  = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    issue_s = launch & req_s & pick_s;
    issue_r = launch & req_r & ~pick_s;
    if (launch) begin
      if (issue_s | issue_r) begin
        state_d = HOLD;
        cnt_d   = C_PULSE;
        s_d     = issue_s;
        r_d     = issue_r;
      end else begin
        state_d = IDLE;
      end
    end

    // A rise arriving while its own pending request is issued queues behind it.
    pend_s_d   = issue_s ? (pend_s_q & rise_s) : (pend_s_q | rise_s);
    pend_r_d   = issue_r ? (pend_r_q & rise_r) : (pend_r_q | rise_r);
    drop_d     = (rise_s & pend_s_q & ~issue_s) | (rise_r & pend_r_q & ~issue_r);
    conflict_d = rise_s & rise_r;
  end

  always_ff @(posedge clk) begin
    if (cl) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      busy_q     <= (state_d != IDLE);
      conflict_q <= conflict_d;
      drop_q     <= drop_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;
  assign drop     = drop_q;

endmodule
`default_nettype wire
